uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Byte FIFO directly downstream of the UART receiver.
- Captures every single-cycle RX_DV strobe with its RX_BYTE and buffers the bytes.
- Presents the buffered bytes to the consuming logic (command parser, loopback TX path) through a valid/ready interface.
- Absorbs bursts at up to 921600 baud while the consumer is busy, and flags any byte lost to overflow.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- SER_CLK  input  1  system clock, same domain as the UART receiver.
- RST  input  1  synchronous reset, active-high.
- RX_DV  input  1  one-cycle strobe: RX_BYTE is valid this cycle.
- RX_BYTE  input  8  received byte.
- OUT_VALID  output  1  FIFO non-empty; OUT_BYTE holds the oldest entry.
- OUT_BYTE  output  8  head-of-FIFO byte; 8'h00 whenever OUT_VALID=0.
- OUT_READY  input  1  consumer accepts the head byte on a cycle where OUT_VALID=1.
- COUNT  output  ADDR_W+1  current occupancy, 0..DEPTH.
- FULL  output  1  COUNT==DEPTH.
- OVERFLOW  output  1  sticky: a byte was dropped.
- CLR_OVF  input  1  clears OVERFLOW.

Behaviour:
- Single clock SER_CLK. All state updates on its rising edge. RST is synchronous and active-high.
- Reset values:
  - wr_ptr=0, rd_ptr=0, COUNT=0.
  - OUT_VALID=0, OUT_BYTE=8'h00, FULL=0, OVERFLOW=0.
  - Memory contents are not reset.
- Write: wr = RX_DV && (!FULL || rd).
  - On wr: mem[wr_ptr] <= RX_BYTE, then wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- Read: rd = OUT_VALID && OUT_READY.
  - On rd: rd_ptr increments modulo DEPTH.
  - OUT_READY is ignored when OUT_VALID=0.
- COUNT update: +1 on wr only, −1 on rd only, unchanged on both or neither.
- Output flags: OUT_VALID = (COUNT!=0) and FULL = (COUNT==DEPTH), both derived from registered COUNT.
- OUT_BYTE = mem[rd_ptr] when OUT_VALID, else 8'h00 (first-word fall-through).
- Latency: a byte written at edge N gives OUT_VALID=1 and the byte on OUT_BYTE after edge N. There is no same-cycle bypass.
- Full and RX_DV with rd in the same cycle: the read frees a slot and the write is accepted. COUNT stays DEPTH and no overflow occurs.
- Full and RX_DV without rd: the byte is dropped. OVERFLOW <= 1. Pointers and COUNT are unchanged, and the stored data is not corrupted.
- Empty and RX_DV with OUT_READY=1: the write is accepted, the read is not, COUNT becomes 1.
- OVERFLOW: set by a drop, cleared by CLR_OVF. If a drop and CLR_OVF occur in the same cycle, set wins (OVERFLOW=1).
- Reset mid-operation: all buffered bytes are discarded. Outputs return to reset values on the next edge, and an RX_DV in the reset cycle is ignored.
- Pointer wrap: after DEPTH writes and DEPTH reads, the pointers return to 0 with no gap and no duplicated byte.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output DROP_CNT [7:0], a saturating count of dropped bytes.
  - Increments on every drop and holds at 8'hFF.
  - Cleared by CLR_OVF and by RST. A drop coinciding with CLR_OVF gives DROP_CNT=1.
- Undefined:
  - The DROP_CNT port and its logic do not exist.
  - OVERFLOW behaviour is identical in both builds.

Test Plan:
- Basic write/read: after reset, RX_DV with 8'hA5, hold OUT_READY=0 → next cycle OUT_VALID=1, OUT_BYTE=8'hA5, COUNT=1. Then OUT_READY=1 for one cycle → OUT_VALID=0, OUT_BYTE=8'h00, COUNT=0.
- Ordering and wrap: write 8'h00..8'h0F with OUT_READY=0 → FULL=1, COUNT=16. Drain all → bytes come out 8'h00..8'h0F in order. Repeat 3 times to cross pointer wrap; order is preserved each pass.
- Overflow: fill 16 bytes, then RX_DV with 8'hEE and OUT_READY=0 → OVERFLOW=1, COUNT=16, and draining yields the original 16 bytes with no 8'hEE. Pulse CLR_OVF → OVERFLOW=0. With UART_RX_FIFO_DROP_CNT_EN, DROP_CNT is 1, then 0 after CLR_OVF.
- Full with simultaneous read/write: when full, assert RX_DV with 8'h77 and OUT_READY together → OVERFLOW stays 0, COUNT stays 16, and 8'h77 is the last byte drained.
- Streaming: back-to-back RX_DV every cycle with OUT_READY held at 1 for 100 cycles of incrementing data → COUNT never exceeds 1, and every byte is delivered once in order.
- Reset mid-operation: with 5 bytes queued, assert RST for one cycle while RX_DV=1 → COUNT=0, OUT_VALID=0, OVERFLOW=0. The next write (8'h3C) is the first byte read out.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ---------------------------------------------------------------------------
// This is a byte FIFO that sits directly behind the UART receiver. Every
// single-cycle RX_DV strobe stores its RX_BYTE. The buffered bytes go to the
// consumer over a first-word fall-through valid/ready interface. When a byte
// arrives while the FIFO is full, the byte is dropped and a sticky OVERFLOW
// flag is set.
//
// Optional feature: define UART_RX_FIFO_DROP_CNT_EN to add DROP_CNT. DROP_CNT
// is a saturating count of dropped bytes. CLR_OVF and RST clear it.
//
// Parameters:
//   DEPTH   number of byte entries (power of two, >= 2)
//   ADDR_W  pointer width, log2(DEPTH)
//
// Ports:
//   SER_CLK    system clock (same domain as the UART receiver)
//   RST        synchronous active-high reset
//   RX_DV      one-cycle strobe qualifying RX_BYTE
//   RX_BYTE    received byte
//   OUT_VALID  FIFO non-empty
//   OUT_BYTE   head byte, 8'h00 while OUT_VALID=0
//   OUT_READY  consumer takes the head byte when OUT_VALID=1
//   COUNT      occupancy 0..DEPTH
//   FULL       COUNT==DEPTH
//   OVERFLOW   sticky drop indicator
//   CLR_OVF    clears OVERFLOW (and DROP_CNT when present)
//   DROP_CNT   saturating drop counter (UART_RX_FIFO_DROP_CNT_EN only)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              SER_CLK,
    input  logic              RST,
    input  logic              RX_DV,
    input  logic [7:0]        RX_BYTE,
    output logic              OUT_VALID,
    output logic [7:0]        OUT_BYTE,
    input  logic              OUT_READY,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              OVERFLOW,
    input  logic              CLR_OVF
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        DROP_CNT
`endif
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic              wr_s, rd_s, drop_s, valid_s, full_s;

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0]        drop_cnt_q, drop_cnt_d;
`endif

    // Derive the status flags from the registered occupancy.
    always_comb begin
        valid_s = (count_q != {(ADDR_W+1){1'b0}});
        full_s  = (count_q == CNT_FULL);
    end

    // Qualify reads and writes, then compute the next pointers, count and flags.
    always_comb begin
        rd_s   = valid_s && OUT_READY;
        // When the FIFO is full, a write is accepted only if a read frees a slot in the same cycle.
        wr_s   = RX_DV && (!full_s || rd_s);
        drop_s = RX_DV && !wr_s;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop takes priority over a clear that arrives in the same cycle.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    // Compute the saturating drop count. A clear that coincides with a drop restarts the count at 1.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (CLR_OVF) begin
            drop_cnt_d = drop_s ? 8'h01 : 8'h00;
        end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'h01;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Register the drop counter.
    always_ff @(posedge SER_CLK) begin
        if (RST) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

    // Register the pointers, occupancy and sticky overflow.
    always_ff @(posedge SER_CLK) begin
        if (RST) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W+1){1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Store the storage array. It has no reset, so writes are suppressed while RST is asserted.
    always_ff @(posedge SER_CLK) begin
        if (!RST && wr_s) begin
            mem_q[wr_ptr_q] <= RX_BYTE;
        end
    end

    // Drive the outputs. The head byte is forced to zero while the FIFO is empty.
    always_comb begin
        OUT_VALID = valid_s;
        FULL      = full_s;
        COUNT     = count_q;
        OVERFLOW  = ovf_q;
        if (valid_s) begin
            OUT_BYTE = mem_q[rd_ptr_q];
        end else begin
            OUT_BYTE = 8'h00;
        end
    end

endmodule
